// File: rtl/serial_tx_pkg.sv
// Shared types for the serial pattern transmitter.
// State encoding and default frame width.
package serial_tx_pkg;

    localparam int TX_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } tx_state_t;

endpackage

// File: rtl/tx_bit_counter.sv
// Loadable bit counter with clear and terminal-count flag.
// Saturates at LAST so it can never wrap.
module tx_bit_counter #(
    parameter int W    = 4,
    parameter int LAST = 7
) (
    input  logic         Clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(LAST));

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: parallel word out LSB first, one bit per Clk.
// Define PARITY_TX_EN to append an even-parity bit after the data bits.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = TX_DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] bit_idx
);

`ifdef PARITY_TX_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    tx_state_t        state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [IDX_W-1:0] cnt;
    logic             tc;
    logic             load;
    logic             cnt_en;

    tx_bit_counter #(
        .W    (IDX_W),
        .LAST (LAST)
    ) u_cnt (
        .Clk (Clk),
        .rst (rst),
        .clr (load),
        .en  (cnt_en),
        .cnt (cnt),
        .tc  (tc)
    );

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        load    = 1'b0;
        cnt_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (tc) begin
                    state_n = DONE;
                end else begin
                    shreg_n = {1'b0, shreg[WIDTH-1:1]};
                    cnt_en  = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            shreg_n = data_in;
        end
    end

`ifdef PARITY_TX_EN
    logic par;

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            par <= 1'b0;
        end else if (load) begin
            par <= ^data_in;
        end
    end

    // Trailing cycle carries the parity bit instead of the drained shreg.
    assign x_out = (state == SHIFT) &&
                   ((cnt == IDX_W'(WIDTH)) ? par : shreg[0]);
`else
    assign x_out = (state == SHIFT) && shreg[0];
`endif

    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign bit_idx = (state == SHIFT) ? cnt : '0;

endmodule
